// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run controller for the single-cycle MIPS `main` core.
// A start pulse holds the core in reset for RST_CYCLES cycles, then runs it
// until a halt request, a stuck PC (optional) or the cycle budget ends the
// run. The stop reason and the executed-cycle count are latched in DONE.
// Optional feature macro: RUN_CTRL_PC_WATCH_EN builds the stuck-PC watch.
module core_run_ctrl #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 15,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  output logic             core_rst_n,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             stuck,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] BUDGET_LAST = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  state_t            state, state_nxt;
  logic [RW-1:0]     rst_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              budget_hit;
  logic              stuck_hit;

`ifdef RUN_CTRL_PC_WATCH_EN
  localparam int SW = $clog2(STALL_LIMIT);

  logic [PC_W-1:0] pc_prev;
  logic            pc_valid;
  logic [SW-1:0]   stall_cnt, stall_nxt;

  // Stall counter look-ahead: the stuck exit happens on the edge that
  // registers the STALL_LIMIT-th equal sample.
  always_comb begin
    stall_nxt = '0;
    if (pc_valid && (pc == pc_prev)) stall_nxt = stall_cnt + SW'(1);
    stuck_hit = (state == S_RUN) && (stall_nxt == SW'(STALL_LIMIT - 1));
  end

  // PC history; cleared outside RUN so the first RUN cycle never matches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_prev   <= '0;
      pc_valid  <= 1'b0;
      stall_cnt <= '0;
    end else if (state != S_RUN) begin
      pc_valid  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pc_prev   <= pc;
      pc_valid  <= 1'b1;
      stall_cnt <= stall_nxt;
    end
  end
`else
  logic pc_unused;

  // Without the PC watch the run can never end as stuck.
  assign stuck_hit = 1'b0;
  assign pc_unused = ^pc;
`endif

  // Saturating increment and budget test on the pre-increment count.
  always_comb begin
    cnt_inc    = (cycle_count == CNT_SAT) ? cycle_count : cycle_count + CNT_W'(1);
    budget_hit = (MAX_CYCLES != 0) && (cycle_count == BUDGET_LAST);
  end

  // Next-state logic for the run sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RESET;
      S_RESET: if (rst_cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN:   if (halt_req || stuck_hit || budget_hit) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RESET;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, stop flags and registered outputs decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      stuck       <= 1'b0;
      core_rst_n  <= 1'b0;
      core_en     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      core_rst_n <= (state_nxt == S_RUN) || (state_nxt == S_DONE);
      core_en    <= (state_nxt == S_RUN);
      running    <= (state_nxt == S_RUN);
      done       <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt     <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            stuck       <= 1'b0;
          end
        end
        S_RESET: begin
          rst_cnt <= rst_cnt + RW'(1);
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          // Halt outranks stuck, stuck outranks budget.
          if (!halt_req) begin
            if (stuck_hit)       stuck   <= 1'b1;
            else if (budget_hit) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Testbench for core_run_ctrl: directed runs with expected stop results
// queued when a run is launched and compared when done rises.
module tb_core_run_ctrl;

  localparam int MAX   = 15;
  localparam int STALL = 4;
  localparam int RSTC  = 2;
`ifdef RUN_CTRL_PC_WATCH_EN
  localparam bit WATCH = 1'b1;
`else
  localparam bit WATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req;
  logic [31:0] pc;
  logic        core_rst_n, core_en, running, done, timeout, stuck;
  logic [15:0] cycle_count;

  logic        start2;
  logic        halt2;
  logic [31:0] pc2;
  logic        core_rst_n2, core_en2, running2, done2, timeout2, stuck2;
  logic [2:0]  cycle_count2;

  typedef struct {
    string tag;
    int    count;
    logic  to;
    logic  st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  core_run_ctrl #(
    .RST_CYCLES(RSTC), .MAX_CYCLES(MAX), .CNT_W(16), .PC_W(32), .STALL_LIMIT(STALL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc(pc),
    .core_rst_n(core_rst_n), .core_en(core_en), .running(running), .done(done),
    .timeout(timeout), .stuck(stuck), .cycle_count(cycle_count)
  );

  core_run_ctrl #(
    .RST_CYCLES(RSTC), .MAX_CYCLES(0), .CNT_W(3), .PC_W(32), .STALL_LIMIT(STALL)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .halt_req(halt2), .pc(pc2),
    .core_rst_n(core_rst_n2), .core_en(core_en2), .running(running2), .done(done2),
    .timeout(timeout2), .stuck(stuck2), .cycle_count(cycle_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start from IDLE/DONE and follow the core reset window into RUN cycle 1.
  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_rst0"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_cnt_clr"}, {16'd0, cycle_count}, 32'd0);
    for (int i = 1; i < RSTC; i++) begin
      @(negedge clk);
      check({tag, "_rstlow"}, {31'd0, core_rst_n}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_rsthi"}, {31'd0, core_rst_n}, 32'd1);
    check({tag, "_run"}, {29'd0, running, core_en, done}, 32'b110);
  endtask

  // Launch a run; pc either increments or settles at 0x08 from RUN cycle 3.
  task automatic run_case(input string tag, input int halt_cycle, input bit pc_hold);
    exp_t e;
    int   stuck_c;
    int   c;
    e.tag   = tag;
    e.count = MAX;
    e.to    = 1'b1;
    e.st    = 1'b0;
    stuck_c = 3 + STALL - 1;
    if (pc_hold && WATCH && stuck_c <= e.count) begin
      e.count = stuck_c;
      e.to    = 1'b0;
      e.st    = 1'b1;
    end
    if (halt_cycle != 0 && halt_cycle <= e.count) begin
      e.count = halt_cycle;
      e.to    = 1'b0;
      e.st    = 1'b0;
    end
    sb.push_back(e);
    do_start(tag);
    c = 1;
    while (c <= 40) begin
      halt_req = (c == halt_cycle);
      pc = pc_hold ? ((c >= 3) ? 32'h8 : 32'((c - 1) * 4)) : 32'(c * 4);
      @(negedge clk);
      if (done) break;
      c++;
    end
    halt_req = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, {31'd0, done}, 32'd1);
    check({e.tag, "_count"}, {16'd0, cycle_count}, 32'(e.count));
    check({e.tag, "_timeout"}, {31'd0, timeout}, {31'd0, e.to});
    check({e.tag, "_stuck"}, {31'd0, stuck}, {31'd0, e.st});
    check({e.tag, "_hold"}, {29'd0, core_rst_n, core_en, running}, 32'b100);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; pc = '0;
    start2 = 1'b0; halt2 = 1'b0; pc2 = '0;
    #1 reset = 1'b0;
    #2;
    check("por_outs", {25'd0, core_rst_n, core_en, running, done, timeout, stuck, 1'b0}, 32'd0);
    check("por_count", {16'd0, cycle_count}, 32'd0);
    #3 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_outs", {26'd0, core_rst_n, core_en, running, done, timeout, stuck}, 32'd0);

    run_case("timeout", 0, 1'b0);

    // halt_req is ignored in DONE: flags and count hold.
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("done_halt_ign", {15'd0, done, cycle_count}, {15'd0, 1'b1, 16'(MAX)});

    run_case("halt7", 7, 1'b0);
    run_case("halt15", 15, 1'b0);
    run_case("pcwatch", 0, 1'b1);

    // Asynchronous reset in RUN cycle 4 aborts the run immediately.
    do_start("abort");
    for (int c = 1; c < 4; c++) begin
      pc = 32'(c * 4);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_outs", {26'd0, core_rst_n, core_en, running, done, timeout, stuck}, 32'd0);
    check("abort_count", {16'd0, cycle_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_case("restart", 3, 1'b0);

    // Unlimited budget, 3-bit count: saturates at 7 and keeps running;
    // start stays high throughout and must be ignored.
    start2 = 1'b1;
    repeat (RSTC + 1) @(negedge clk);
    check("sat_run", {31'd0, running2}, 32'd1);
    for (int c = 1; c <= 20; c++) begin
      pc2 = 32'(c * 4);
      @(negedge clk);
      if (c == 6) check("sat_c6", {29'd0, cycle_count2}, 32'd6);
      if (c == 7) check("sat_c7", {29'd0, cycle_count2}, 32'd7);
    end
    check("sat_count", {29'd0, cycle_count2}, 32'd7);
    check("sat_flags", {28'd0, running2, done2, timeout2, stuck2}, 32'b1000);
    start2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller for the single-cycle MIPS `main` core. It sequences the core's reset and clock-enable from one start pulse, holding the core in reset for a parametrised number of cycles, then running it. It stops the run on a halt request from the core, on a cycle budget, or (optionally) on a stuck PC, and latches the stop reason and the executed-cycle count. It replaces fixed-length reset and clock-count stimulus with a reusable, synthesizable block between board/bench control and `main`.

## Interface
Parameters:
- `RST_CYCLES`, 2, cycles `core_rst_n` is held low after start; must be ≥1.
- `MAX_CYCLES`, 15, run budget in RUN cycles; 0 = unlimited.
- `CNT_W`, 16, width of `cycle_count`.
- `PC_W`, 32, width of `pc`.
- `STALL_LIMIT`, 4, consecutive unchanged-PC RUN cycles that count as stuck; must be ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset of this block.
- `start`  in  1  level-sampled start request.
- `halt_req`  in  1  core signals end of program.
- `pc`  in  PC_W  core program counter; ignored unless the PC watch is compiled in.
- `core_rst_n`  out  1  active-low reset to `main`.
- `core_en`  out  1  clock enable to `main`.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  run ended on budget.
- `stuck`  out  1  run ended on PC watch.
- `cycle_count`  out  CNT_W  RUN cycles executed.

## Operation
- All outputs are registered. While `reset`=0, outputs are `core_rst_n`=0, `core_en`=0, `running`=0, `done`=0, `timeout`=0, `stuck`=0, `cycle_count`=0, and the state is IDLE.
- IDLE: `core_rst_n`=0. When `start`=1 at an edge, go to RESET and clear the reset counter.
- RESET: `core_rst_n`=0 and `core_en`=0. The counter increments each edge. At the edge where it equals RST_CYCLES-1, go to RUN. Clear `cycle_count`, `done`, `timeout` and `stuck` on entry.
- RUN: `core_rst_n`=1, `core_en`=1, `running`=1. `cycle_count` increments on every edge in RUN, including the exit edge, and saturates at 2^CNT_W-1. Exit to DONE at the first edge where any of the following holds, in priority order:
  - `halt_req`=1. All flags stay 0.
  - The stuck condition is met. `stuck`=1.
  - MAX_CYCLES≠0 and the pre-increment count equals MAX_CYCLES-1. `timeout`=1.
- DONE: `core_en`=0 and `core_rst_n`=1, so core state is preserved for inspection. `done`=1. Flags and count hold. `start`=1 goes to RESET.
- `start` is ignored in RESET and RUN.
- `halt_req` is ignored outside RUN.
- An asynchronous `reset` assertion at any time forces the reset values immediately and aborts the run.

## Timing
- From the edge sampling `start` to `core_rst_n` rising: RST_CYCLES+1 edges.
- `core_rst_n` is low for exactly RST_CYCLES cycles after the start edge, in addition to the time spent in IDLE.
- `halt_req` asserted during the k-th RUN cycle (1-based) gives `done`=1 and `cycle_count`=k after that edge. `core_en` falls on the same edge.
- A timeout run ends with `cycle_count`=MAX_CYCLES.
- A simultaneous halt and budget exit reports `timeout`=0.
- Saturation at 2^CNT_W-1 does not by itself end the run.

## Configuration
- Macro `RUN_CTRL_PC_WATCH_EN`.
- When defined:
  - `pc` is registered each RUN cycle.
  - A stall counter increments when `pc` equals the previous RUN-cycle value and resets to 0 otherwise.
  - The stuck condition is stall counter = STALL_LIMIT-1, i.e. STALL_LIMIT equal consecutive samples.
  - The history is cleared on RUN entry, so the first RUN cycle never matches.
- When undefined: no PC logic is built, `stuck` is tied to 0, and `pc` is unused.

## Test plan
- Defaults: `reset` low 5 ns then high; `start` for 1 cycle. Required: `core_rst_n` low for 2 cycles after the start edge, then `running`=1; after 15 RUN cycles `done`=1, `timeout`=1, `cycle_count`=15, `core_en`=0.
- `halt_req` pulsed in RUN cycle 7. Required: `done`=1, `timeout`=0, `cycle_count`=7.
- `halt_req` asserted in RUN cycle 15. Required: `timeout`=0, `cycle_count`=15 (halt priority).
- `reset` dropped in RUN cycle 4. Required: all outputs immediately at reset values. A new `start` after release gives a full 2-cycle reset, and `cycle_count` restarts from 0.
- MAX_CYCLES=0, CNT_W=3, 20 cycles. Required: `cycle_count` saturates at 7 and `running` stays 1; `start` is ignored throughout.
- With `RUN_CTRL_PC_WATCH_EN`, `pc` = 0x00, 0x04, 0x08, then held at 0x08. Required: `stuck`=1, `done`=1 after 4 equal samples, `cycle_count`=6. Without the macro the same stimulus runs to timeout.
